// File: rtl/seq_alu_muldiv.sv
// Sequential ALU with single-cycle ops plus shift-add multiply and restoring divide.
// Ports: Clock, Reset (async low), Start/Op/A/B/WF in; Busy/Done/Result/ResultHi/FlagsOut/DivByZero out.
module seq_alu_muldiv #(
  parameter int WIDTH = 32,
  localparam int CNTW = $clog2(WIDTH) + 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WF,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic [3:0]       FlagsOut,
  output logic             DivByZero
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LSL  = 4'd6;
  localparam logic [3:0] OP_LSR  = 4'd7;
  localparam logic [3:0] OP_ASR  = 4'd8;
  localparam logic [3:0] OP_MULU = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic             div_q, wf_q;

  logic accept, long_op, last_it;

  assign accept  = Start && (state_q == IDLE);
  assign long_op = (Op == OP_MULU) || ((Op == OP_DIVU) && (|B));
  assign last_it = (cnt_q == CNTW'(1));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state_q)
      IDLE: if (Start) state_d = long_op ? RUN : DONE;
      RUN: begin
        Busy = 1'b1;
        if (last_it) state_d = DONE;
      end
      DONE: begin
        Busy    = 1'b1;
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle ops are evaluated straight from the inputs at accept,
  // so the result is already registered when Done rises.
  logic [WIDTH:0]   add_s, sub_s;
  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_c, sc_o, sc_fix;
  logic [3:0]       sc_fixv, sc_flags;
  logic             cin;

  assign cin   = (Op == OP_ADC) && FlagsOut[2];
  assign add_s = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
  assign sub_s = {1'b0, A} - {1'b0, B};

  always_comb begin
    sc_res  = '0;
    sc_hi   = '0;
    sc_c    = 1'b0;
    sc_o    = 1'b0;
    sc_fix  = 1'b0;
    sc_fixv = 4'b0000;
    case (Op)
      OP_ADD, OP_ADC: begin
        sc_res = add_s[WIDTH-1:0];
        sc_c   = add_s[WIDTH];
        sc_o   = (A[WIDTH-1] == B[WIDTH-1]) &&
                 (sc_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_s[WIDTH-1:0];
        sc_c   = sub_s[WIDTH];
        sc_o   = (A[WIDTH-1] != B[WIDTH-1]) &&
                 (sc_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: sc_res = A & B;
      OP_OR:  sc_res = A | B;
      OP_XOR: sc_res = A ^ B;
      OP_LSL: begin
        sc_res = {A[WIDTH-2:0], 1'b0};
        sc_c   = A[WIDTH-1];
      end
      OP_LSR: begin
        sc_res = {1'b0, A[WIDTH-1:1]};
        sc_c   = A[0];
      end
      OP_ASR: sc_res = {A[WIDTH-1], A[WIDTH-1:1]};
      OP_MULU: ;
      OP_DIVU: begin
        // Only reached here with B == 0
        sc_res  = '1;
        sc_hi   = A;
        sc_fix  = 1'b1;
        sc_fixv = 4'b0011;
      end
      default: begin
        sc_fix  = 1'b1;
        sc_fixv = 4'b1000;
      end
    endcase
    sc_flags = sc_fix ? sc_fixv :
               {~|sc_res, sc_c, sc_res[WIDTH-1], sc_o};
  end

  // One multiply or divide iteration; hi/lo hold product halves
  // or remainder/quotient.
  logic [WIDTH:0]   mul_s, div_sh;
  logic [WIDTH-1:0] div_diff, it_hi, it_lo;
  logic             div_ge;
  logic [3:0]       lf_flags;

  assign mul_s    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, b_q};
  assign div_diff = div_sh[WIDTH-1:0] - b_q;

  always_comb begin
    if (div_q) begin
      it_hi    = div_ge ? div_diff : div_sh[WIDTH-1:0];
      it_lo    = {lo_q[WIDTH-2:0], div_ge};
      lf_flags = {~|it_lo, 1'b0, it_lo[WIDTH-1], 1'b0};
    end else begin
      it_hi    = mul_s[WIDTH:1];
      it_lo    = {mul_s[0], lo_q[WIDTH-1:1]};
      lf_flags = {~|{it_hi, it_lo}, |it_hi, it_hi[WIDTH-1], |it_hi};
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      div_q     <= 1'b0;
      wf_q      <= 1'b0;
      Result    <= '0;
      ResultHi  <= '0;
      FlagsOut  <= '0;
      DivByZero <= 1'b0;
    end else if (accept) begin
      cnt_q     <= CNTW'(WIDTH);
      hi_q      <= '0;
      lo_q      <= A;
      b_q       <= B;
      div_q     <= (Op == OP_DIVU);
      wf_q      <= WF;
      DivByZero <= (Op == OP_DIVU) && ~|B;
      if (!long_op) begin
        Result   <= sc_res;
        ResultHi <= sc_hi;
        if (WF) FlagsOut <= sc_flags;
      end
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q - CNTW'(1);
      hi_q  <= it_hi;
      lo_q  <= it_lo;
      if (last_it) begin
        Result   <= it_lo;
        ResultHi <= it_hi;
        if (wf_q) FlagsOut <= lf_flags;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu_muldiv.sv
// Directed scoreboard bench for seq_alu_muldiv at WIDTH=32.
// Expected results are queued at issue and compared when Done is seen.
module tb_seq_alu_muldiv;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [3:0]  Op = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        WF = 1'b0;
  logic        Busy, Done, DivByZero;
  logic [31:0] Result, ResultHi;
  logic [3:0]  FlagsOut;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [31:0] hi;
    logic [3:0]  fl;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  seq_alu_muldiv #(.WIDTH(32)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .A(A), .B(B), .WF(WF), .Busy(Busy), .Done(Done),
    .Result(Result), .ResultHi(ResultHi), .FlagsOut(FlagsOut),
    .DivByZero(DivByZero)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(Busy), 0);
    chk({tag, "_done"}, 64'(Done), 0);
    chk({tag, "_res"}, 64'(Result), 0);
    chk({tag, "_hi"}, 64'(ResultHi), 0);
    chk({tag, "_flags"}, 64'(FlagsOut), 0);
    chk({tag, "_dbz"}, 64'(DivByZero), 0);
  endtask

  task automatic start_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic wf, input logic [31:0] res,
                          input logic [31:0] hi, input logic [3:0] fl,
                          input logic dbz, input int lat);
    exp_t e;
    e.tag = tag; e.res = res; e.hi = hi;
    e.fl = fl; e.dbz = dbz; e.lat = lat;
    sb.push_back(e);
    Start = 1'b1; Op = op; A = a; B = b; WF = wf;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    A = $urandom;
    B = $urandom;
    WF = ~wf;
  endtask

  task automatic finish_op(input int poke);
    exp_t e;
    int   cyc;
    bit   seen;
    e = sb.pop_front();
    cyc = 0;
    seen = 0;
    while (cyc < 100 && !seen) begin
      @(negedge Clock);
      cyc++;
      if (cyc == poke) begin
        Start = 1'b1;
        Op = 4'd0;
      end else begin
        Start = 1'b0;
      end
      if (Done) seen = 1;
    end
    Start = 1'b0;
    chk({e.tag, "_done_seen"}, 64'(seen), 1);
    chk({e.tag, "_latency"}, 64'(cyc), 64'(e.lat));
    chk({e.tag, "_res"}, 64'(Result), 64'(e.res));
    chk({e.tag, "_hi"}, 64'(ResultHi), 64'(e.hi));
    chk({e.tag, "_flags"}, 64'(FlagsOut), 64'(e.fl));
    chk({e.tag, "_dbz"}, 64'(DivByZero), 64'(e.dbz));
    @(negedge Clock);
    chk({e.tag, "_pulse"}, 64'(Done), 0);
    chk({e.tag, "_idle"}, 64'(Busy), 0);
  endtask

  initial begin
    int dones;
    repeat (2) @(negedge Clock);
    chk_zero("reset");
    Reset = 1'b1;
    @(negedge Clock);

    start_op("add", 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b1,
             32'd0, 32'd0, 4'b1100, 1'b0, 1);
    finish_op(0);
    start_op("adc", 4'd1, 32'd5, 32'd6, 1'b1,
             32'd12, 32'd0, 4'b0000, 1'b0, 1);
    finish_op(0);
    start_op("mulu_poke", 4'd9, 32'h0001_0000, 32'h0001_0000, 1'b1,
             32'd0, 32'd1, 4'b0101, 1'b0, 33);
    finish_op(5);
    start_op("divu", 4'd10, 32'd100, 32'd7, 1'b1,
             32'd14, 32'd2, 4'b0000, 1'b0, 33);
    finish_op(0);
    start_op("divu0", 4'd10, 32'd9, 32'd0, 1'b1,
             32'hFFFF_FFFF, 32'd9, 4'b0011, 1'b1, 1);
    finish_op(0);
    start_op("lsl", 4'd6, 32'h8000_0001, 32'd0, 1'b1,
             32'h0000_0002, 32'd0, 4'b0100, 1'b0, 1);
    finish_op(0);
    start_op("asr", 4'd8, 32'h8000_0000, 32'd0, 1'b1,
             32'hC000_0000, 32'd0, 4'b0010, 1'b0, 1);
    finish_op(0);
    start_op("lsr", 4'd7, 32'h0000_0003, 32'd0, 1'b1,
             32'd1, 32'd0, 4'b0100, 1'b0, 1);
    finish_op(0);
    start_op("sub_ovf", 4'd2, 32'h8000_0000, 32'd1, 1'b1,
             32'h7FFF_FFFF, 32'd0, 4'b0001, 1'b0, 1);
    finish_op(0);
    start_op("xor", 4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1,
             32'h0FF0_0FF0, 32'd0, 4'b0000, 1'b0, 1);
    finish_op(0);
    start_op("mulu_max", 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
             32'd1, 32'hFFFF_FFFE, 4'b0111, 1'b0, 33);
    finish_op(0);
    start_op("divu_max", 4'd10, 32'hFFFF_FFFF, 32'd10, 1'b1,
             32'h1999_9999, 32'd5, 4'b0000, 1'b0, 33);
    finish_op(0);

    Start = 1'b1; Op = 4'd9; A = 32'd1234; B = 32'd5678; WF = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (10) @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge Clock);
    Reset = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge Clock);
      if (Done) dones++;
    end
    chk("midrst_nodone", 64'(dones), 0);

    start_op("and_z", 4'd3, 32'd0, 32'h0000_FFFF, 1'b1,
             32'd0, 32'd0, 4'b1000, 1'b0, 1);
    finish_op(0);
    start_op("sub_nowf", 4'd2, 32'd3, 32'd5, 1'b0,
             32'hFFFF_FFFE, 32'd0, 4'b1000, 1'b0, 1);
    finish_op(0);
    start_op("illegal", 4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1,
             32'd0, 32'd0, 4'b1000, 1'b0, 1);
    finish_op(0);

    chk("sb_empty", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
